reg_file_arbiter: RTL

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_file_arbiter_if.sv | 38 +++
 rtl/reg_file_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/reg_file_arbiter_if.sv
// Two-port request/response bus plus register-file side signals of the arbiter.
// The arbiter uses the slave modport; the requesters and register file sit on the master side.
interface reg_file_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [3:0]        addr0;
  logic [3:0]        addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;
  logic [3:0]        rf_addr;
  logic              rf_ce;
  logic [DATA_W-1:0] rf_data_in;
  logic [DATA_W-1:0] rf_data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_data_out,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
           rf_addr, rf_ce, rf_data_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_data_out,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
           rf_addr, rf_ce, rf_data_in
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// Round-robin two-port arbiter for a registered-read register file: grant, issue, respond (3 cycles).
// Grant is combinational in IDLE; a requester simply holds REQ until granted, no other backpressure.
module reg_file_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8
) (
  input logic               CLK,
  input logic               RSTN,
  reg_file_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic              last;
  logic              cmd_port;
  logic              cmd_we;
  logic [3:0]        cmd_addr;
  logic              done0_q;
  logic              done1_q;
  logic              err_q;
  logic              rf_ce_q;
  logic [3:0]        rf_addr_q;
  logic [DATA_W-1:0] rf_data_in_q;

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [3:0]        sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic              cmd_in_range;
  logic              grant_ok;
  logic              rd_ok;

  // On a tie the port that did not win last time gets the grant.
  assign any_req      = bus.req0 | bus.req1;
  assign win          = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign sel_we       = win ? bus.we1    : bus.we0;
  assign sel_addr     = win ? bus.addr1  : bus.addr0;
  assign sel_wdata    = win ? bus.wdata1 : bus.wdata0;
  assign sel_in_range = ({28'd0, sel_addr} < 32'(NUM_REGS));
  assign cmd_in_range = ({28'd0, cmd_addr} < 32'(NUM_REGS));

  assign grant_ok = RSTN & (state == IDLE) & any_req;
  assign bus.gnt0 = grant_ok & ~win;
  assign bus.gnt1 = grant_ok &  win;

  // Read data is only forwarded for in-range reads during the winner's DONE cycle.
  assign rd_ok      = ~cmd_we & ~err_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.err0   = done0_q & err_q;
  assign bus.err1   = done1_q & err_q;
  assign bus.rdata0 = (done0_q & rd_ok) ? bus.rf_data_out : '0;
  assign bus.rdata1 = (done1_q & rd_ok) ? bus.rf_data_out : '0;

  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_ce      = rf_ce_q;
  assign bus.rf_data_in = rf_data_in_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state        <= IDLE;
      last         <= 1'b1;
      cmd_port     <= 1'b0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
      rf_ce_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_in_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= ISSUE;
            cmd_port     <= win;
            cmd_we       <= sel_we;
            cmd_addr     <= sel_addr;
            last         <= win;
            rf_addr_q    <= sel_addr;
            rf_data_in_q <= sel_wdata;
            rf_ce_q      <= sel_we & sel_in_range;
          end
        end
        ISSUE: begin
          state        <= RESP;
          rf_ce_q      <= 1'b0;
          rf_data_in_q <= '0;
          done0_q      <= ~cmd_port;
          done1_q      <= cmd_port;
          err_q        <= ~cmd_in_range;
        end
        RESP: begin
          state     <= IDLE;
          done0_q   <= 1'b0;
          done1_q   <= 1'b0;
          err_q     <= 1'b0;
          rf_addr_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
